// File: rtl/comparador_pkg.sv
// Shared types and width helpers for the serial magnitude comparator.
package comparador_pkg;

    // Legal operand width range.
    localparam int unsigned LARGURA_MIN = 2;
    localparam int unsigned LARGURA_MAX = 32;

    // FSM state encoding. Kept as plain constants so older tools can still read it.
    typedef logic [0:0] estado_t;

    localparam estado_t OCIOSO  = 1'b0;
    localparam estado_t COMPARA = 1'b1;

    // Width of the cycle counter, which must hold values 0..largura.
    function automatic int unsigned largura_ciclos(input int unsigned largura);
        return $clog2(largura + 1);
    endfunction

    // Width of the bit-index counter, which must hold values 0..largura-1.
    function automatic int unsigned largura_indice(input int unsigned largura);
        return (largura > 1) ? $clog2(largura) : 1;
    endfunction

endpackage : comparador_pkg

// File: rtl/comparador_serial.sv
// Serial MSB-first magnitude comparator with a start/valid handshake and
// a runtime unsigned / signed (two's complement) mode. Stops on the first
// differing bit, so latency is 1..LARGURA cycles after accept.
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int unsigned LARGURA = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                inicio,
    input  logic                                com_sinal,
    input  logic [LARGURA-1:0]                  a,
    input  logic [LARGURA-1:0]                  b,
    output logic                                ocupado,
    output logic                                valido,
    output logic                                maior,
    output logic                                menor,
    output logic                                igual,
    output logic [largura_ciclos(LARGURA)-1:0]  ciclos
);

    localparam int unsigned CW = largura_ciclos(LARGURA);
    localparam int unsigned IW = largura_indice(LARGURA);

    // Index of the sign bit, where the first examined bit lives.
    localparam logic [IW-1:0] IDX_MSB = IW'(LARGURA - 1);

    // State and datapath registers.
    estado_t              estado_q,  estado_d;
    logic [LARGURA-1:0]   a_q,       a_d;
    logic [LARGURA-1:0]   b_q,       b_d;
    logic                 sinal_q,   sinal_d;
    logic [IW-1:0]        idx_q,     idx_d;
    logic                 ocupado_q, ocupado_d;
    logic                 valido_q,  valido_d;
    logic                 maior_q,   maior_d;
    logic                 menor_q,   menor_d;
    logic                 igual_q,   igual_d;
    logic [CW-1:0]        ciclos_q,  ciclos_d;

    // Per-cycle decision terms derived from the shift-register heads.
    logic                 bit_a_c;
    logic                 bit_b_c;
    logic                 difere_c;
    logic                 inverte_c;
    logic                 ultimo_c;

    // Heads of the shift registers and the polarity rule for the sign bit.
    assign bit_a_c   = a_q[LARGURA-1];
    assign bit_b_c   = b_q[LARGURA-1];
    assign difere_c  = bit_a_c ^ bit_b_c;
    assign inverte_c = sinal_q && (idx_q == IDX_MSB);
    assign ultimo_c  = (idx_q == '0);

    // State register plus all datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= OCIOSO;
            a_q       <= '0;
            b_q       <= '0;
            sinal_q   <= 1'b0;
            idx_q     <= '0;
            ocupado_q <= 1'b0;
            valido_q  <= 1'b0;
            maior_q   <= 1'b0;
            menor_q   <= 1'b0;
            igual_q   <= 1'b0;
            ciclos_q  <= '0;
        end else begin
            estado_q  <= estado_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sinal_q   <= sinal_d;
            idx_q     <= idx_d;
            ocupado_q <= ocupado_d;
            valido_q  <= valido_d;
            maior_q   <= maior_d;
            menor_q   <= menor_d;
            igual_q   <= igual_d;
            ciclos_q  <= ciclos_d;
        end
    end

    // Next-state and result logic; everything holds unless a transition acts.
    always_comb begin
        estado_d  = estado_q;
        a_d       = a_q;
        b_d       = b_q;
        sinal_d   = sinal_q;
        idx_d     = idx_q;
        ocupado_d = ocupado_q;
        valido_d  = 1'b0;
        maior_d   = maior_q;
        menor_d   = menor_q;
        igual_d   = igual_q;
        ciclos_d  = ciclos_q;

        case (estado_q)
            OCIOSO: begin
                // Accept: snapshot operands and mode, clear the previous result.
                if (inicio) begin
                    a_d       = a;
                    b_d       = b;
                    sinal_d   = com_sinal;
                    idx_d     = IDX_MSB;
                    maior_d   = 1'b0;
                    menor_d   = 1'b0;
                    igual_d   = 1'b0;
                    ciclos_d  = '0;
                    ocupado_d = 1'b1;
                    estado_d  = COMPARA;
                end
            end

            COMPARA: begin
                ciclos_d = ciclos_q + CW'(1);
                if (difere_c) begin
                    // First differing bit decides; the sign bit reads inverted in signed mode.
                    if (bit_a_c ^ inverte_c) begin
                        maior_d = 1'b1;
                    end else begin
                        menor_d = 1'b1;
                    end
                    valido_d  = 1'b1;
                    ocupado_d = 1'b0;
                    estado_d  = OCIOSO;
                end else if (ultimo_c) begin
                    // Every bit matched.
                    igual_d   = 1'b1;
                    valido_d  = 1'b1;
                    ocupado_d = 1'b0;
                    estado_d  = OCIOSO;
                end else begin
                    // Bits match so far: bring the next bit to the head.
                    a_d   = {a_q[LARGURA-2:0], 1'b0};
                    b_d   = {b_q[LARGURA-2:0], 1'b0};
                    idx_d = idx_q - IW'(1);
                end
            end

            default: begin
                estado_d  = OCIOSO;
                ocupado_d = 1'b0;
            end
        endcase
    end

    // All outputs come straight from registers.
    assign ocupado = ocupado_q;
    assign valido  = valido_q;
    assign maior   = maior_q;
    assign menor   = menor_q;
    assign igual   = igual_q;
    assign ciclos  = ciclos_q;

endmodule : comparador_serial

// File: tb/tb_comparador_serial.sv
// Self-checking bench for comparador_serial: a 4-bit and an 8-bit instance
// checked against a behavioural model of the comparison and its latency.
module tb_comparador_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       inicio4, inicio8;
    logic       s_in;
    logic [7:0] a_in, b_in;

    logic       ocupado4, valido4, maior4, menor4, igual4;
    logic [2:0] ciclos4;
    logic       ocupado8, valido8, maior8, menor8, igual8;
    logic [3:0] ciclos8;

    // Selected-instance view used by the shared scenario task.
    logic       use8;
    logic       o_ocupado, o_valido, o_maior, o_menor, o_igual;
    logic [3:0] o_ciclos;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    comparador_serial #(.LARGURA(4)) dut4 (
        .clk(clk), .rst(rst), .inicio(inicio4), .com_sinal(s_in),
        .a(a_in[3:0]), .b(b_in[3:0]),
        .ocupado(ocupado4), .valido(valido4), .maior(maior4),
        .menor(menor4), .igual(igual4), .ciclos(ciclos4)
    );

    comparador_serial #(.LARGURA(8)) dut8 (
        .clk(clk), .rst(rst), .inicio(inicio8), .com_sinal(s_in),
        .a(a_in), .b(b_in),
        .ocupado(ocupado8), .valido(valido8), .maior(maior8),
        .menor(menor8), .igual(igual8), .ciclos(ciclos8)
    );

    always_comb begin
        o_ocupado = use8 ? ocupado8 : ocupado4;
        o_valido  = use8 ? valido8  : valido4;
        o_maior   = use8 ? maior8   : maior4;
        o_menor   = use8 ? menor8   : menor4;
        o_igual   = use8 ? igual8   : igual4;
        o_ciclos  = use8 ? ciclos8  : {1'b0, ciclos4};
    end

    // Reference: numeric compare of the operands, latency = first differing bit from MSB + 1.
    function automatic void model(input logic [7:0] av, input logic [7:0] bv, input bit s,
                                  input int l, output logic [2:0] flags, output int k);
        int va, vb;
        va = int'(av) & ((1 << l) - 1);
        vb = int'(bv) & ((1 << l) - 1);
        if (s && av[l-1]) va = va - (1 << l);
        if (s && bv[l-1]) vb = vb - (1 << l);
        if (va > vb)      flags = 3'b100;
        else if (va < vb) flags = 3'b010;
        else              flags = 3'b001;
        k = l;
        for (int i = l - 1; i >= 0; i--) begin
            if (av[i] != bv[i]) begin
                k = l - i;
                break;
            end
        end
    endfunction

    // One full comparison on the selected instance; operands are scrambled while busy.
    task automatic run_cmp(input bit w8, input logic [7:0] av, input logic [7:0] bv,
                           input bit s, input string tag);
        logic [2:0] ef, held;
        int ek, n, l;
        l = w8 ? 8 : 4;
        model(av, bv, s, l, ef, ek);
        @(negedge clk);
        use8 = w8;
        a_in = av; b_in = bv; s_in = s;
        if (w8) inicio8 = 1'b1; else inicio4 = 1'b1;
        @(negedge clk);
        inicio4 = 1'b0; inicio8 = 1'b0;
        checks++;
        if (o_ocupado !== 1'b1 || o_valido !== 1'b0 || {o_maior, o_menor, o_igual} !== 3'b000
            || o_ciclos !== 4'd0) begin
            errors++;
            $display("FAIL %s accept: ocupado=%b valido=%b flags=%b ciclos=%0d, want 1 0 000 0",
                     tag, o_ocupado, o_valido, {o_maior, o_menor, o_igual}, o_ciclos);
        end
        n = 0;
        do begin
            a_in = 8'($urandom); b_in = 8'($urandom); s_in = 1'($urandom);
            @(negedge clk);
            n++;
        end while (o_valido !== 1'b1 && n <= l + 2);
        checks++;
        if (n !== ek) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, want %0d", tag, n, ek);
        end
        checks++;
        if ({o_maior, o_menor, o_igual} !== ef || o_ocupado !== 1'b0) begin
            errors++;
            $display("FAIL %s result: flags(maior,menor,igual)=%b ocupado=%b, want %b 0",
                     tag, {o_maior, o_menor, o_igual}, o_ocupado, ef);
        end
        checks++;
        if (o_ciclos !== 4'(ek)) begin
            errors++;
            $display("FAIL %s ciclos: got %0d, want %0d", tag, o_ciclos, ek);
        end
        held = {o_maior, o_menor, o_igual};
        @(negedge clk);
        checks++;
        if (o_valido !== 1'b0 || o_ocupado !== 1'b0 || {o_maior, o_menor, o_igual} !== ef
            || o_ciclos !== 4'(ek)) begin
            errors++;
            $display("FAIL %s hold: valido=%b ocupado=%b flags=%b ciclos=%0d, want 0 0 %b %0d",
                     tag, o_valido, o_ocupado, held, o_ciclos, ef, ek);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; inicio4 = 1'b0; inicio8 = 1'b0;
        a_in = 8'hA5; b_in = 8'h5A; s_in = 1'b0; use8 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ocupado4, valido4, maior4, menor4, igual4, ciclos4,
             ocupado8, valido8, maior8, menor8, igual8, ciclos8} !== '0) begin
            errors++;
            $display("FAIL reset_values: dut4=%b%b%b%b%b/%0d dut8=%b%b%b%b%b/%0d, want all 0",
                     ocupado4, valido4, maior4, menor4, igual4, ciclos4,
                     ocupado8, valido8, maior8, menor8, igual8, ciclos8);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_plan_4bit();
        run_cmp(1'b0, 8'd10, 8'd10, 1'b0, "eq4_10_10");
        run_cmp(1'b0, 8'd15, 8'd0,  1'b0, "msb4_15_0");
        run_cmp(1'b0, 8'd0,  8'd15, 1'b0, "msb4_0_15");
        run_cmp(1'b0, 8'd5,  8'd3,  1'b0, "low4_5_3");
        run_cmp(1'b0, 8'd2,  8'd12, 1'b0, "low4_2_12");
    endtask

    task automatic test_signed_8bit();
        run_cmp(1'b1, 8'hFF, 8'h01, 1'b1, "sgn8_m1_1");
        run_cmp(1'b1, 8'hFF, 8'h01, 1'b0, "uns8_ff_1");
        run_cmp(1'b1, 8'h80, 8'h80, 1'b1, "sgn8_80_80");
        run_cmp(1'b1, 8'h7F, 8'h80, 1'b1, "sgn8_7f_80");
        run_cmp(1'b1, 8'h12, 8'h13, 1'b1, "sgn8_bit0");
    endtask

    task automatic test_random();
        logic [7:0] av, bv;
        for (int i = 0; i < 60; i++) begin
            av = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       bv = av;
                1:       bv = av ^ (8'd1 << $urandom_range(0, 7));
                default: bv = 8'($urandom);
            endcase
            run_cmp(i % 3 != 0, av, bv, 1'($urandom), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_ignore_busy();
        int n;
        use8 = 1'b1;
        @(negedge clk);
        a_in = 8'h55; b_in = 8'h55; s_in = 1'b1; inicio8 = 1'b1;
        @(negedge clk);
        inicio8 = 1'b0;
        @(negedge clk);
        a_in = 8'h00; b_in = 8'hFF; s_in = 1'b0; inicio8 = 1'b1;
        @(negedge clk);
        inicio8 = 1'b0;
        n = 2;
        while (valido8 !== 1'b1 && n <= 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 8 || {maior8, menor8, igual8} !== 3'b001 || ciclos8 !== 4'd8) begin
            errors++;
            $display("FAIL busy_ignore: cycles=%0d flags=%b ciclos=%0d, want 8 001 8",
                     n, {maior8, menor8, igual8}, ciclos8);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ocupado8 !== 1'b0 || {maior8, menor8, igual8} !== 3'b001) begin
            errors++;
            $display("FAIL busy_not_queued: ocupado=%b flags=%b, want 0 001",
                     ocupado8, {maior8, menor8, igual8});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        use8 = 1'b1;
        @(negedge clk);
        a_in = 8'h80; b_in = 8'h00; s_in = 1'b0; inicio8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (valido8 !== 1'b1 || maior8 !== 1'b1 || ciclos8 !== 4'd1) begin
            errors++;
            $display("FAIL b2b_first: valido=%b maior=%b ciclos=%0d, want 1 1 1",
                     valido8, maior8, ciclos8);
        end
        a_in = 8'h10; b_in = 8'h20; s_in = 1'b0;
        @(negedge clk);
        inicio8 = 1'b0;
        checks++;
        if (ocupado8 !== 1'b1 || valido8 !== 1'b0 || {maior8, menor8, igual8} !== 3'b000
            || ciclos8 !== 4'd0) begin
            errors++;
            $display("FAIL b2b_accept: ocupado=%b valido=%b flags=%b ciclos=%0d, want 1 0 000 0",
                     ocupado8, valido8, {maior8, menor8, igual8}, ciclos8);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (valido8 !== 1'b1 && n <= 10);
        checks++;
        if (n !== 3 || {maior8, menor8, igual8} !== 3'b010 || ciclos8 !== 4'd3) begin
            errors++;
            $display("FAIL b2b_second: cycles=%0d flags=%b ciclos=%0d, want 3 010 3",
                     n, {maior8, menor8, igual8}, ciclos8);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        bit seen_valid;
        use8 = 1'b1;
        @(negedge clk);
        a_in = 8'h3C; b_in = 8'h3C; s_in = 1'b0; inicio8 = 1'b1;
        @(negedge clk);
        inicio8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({ocupado8, valido8, maior8, menor8, igual8} !== 5'b0 || ciclos8 !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_op: outputs=%b ciclos=%0d, want 00000 0",
                     {ocupado8, valido8, maior8, menor8, igual8}, ciclos8);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (valido8 === 1'b1 || ocupado8 === 1'b1) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid) begin
            errors++;
            $display("FAIL reset_no_valido: activity after abort seen=1, want 0");
        end
        run_cmp(1'b1, 8'h81, 8'h7F, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_plan_4bit();
        test_signed_8bit();
        test_ignore_busy();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_comparador_serial
